ram_port_arbiter: RTL and testbench

Shares one `ram_sync_1r1w`-style memory between `NREQ` requesters. Each cycle it grants at most one read and at most one write, using independent round-robin arbiters. It steers the granted read address and write signals onto the RAM ports. One cycle later it returns the read data, tagged by requester. Same-cycle read-after-write to one address is forwarded, so every granted read observes all writes granted up to and including its own cycle.

---
 rtl/ram_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous 1R1W RAM between NREQ requesters. Reads and writes have
// independent round-robin arbiters, and same-cycle read-after-write collisions are forwarded.

`ifndef ADDR_LEN
`define ADDR_LEN 8
`endif
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

// Round-robin picker: grants the first requester at or above ptr, wrapping around.
module ram_rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any,
  output logic [PW-1:0] ptr_nxt
);

  logic [PW-1:0] pos;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int k = 0; k < N; k++) begin
      pos = PW'((int'(ptr) + k) % N);
      if (!any && req[pos]) begin
        any      = 1'b1;
        idx      = pos;
        gnt[pos] = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner; the caller only loads it when a grant happened.
  assign ptr_nxt = (idx == PW'(N - 1)) ? '0 : idx + PW'(1);

endmodule

module ram_port_arbiter #(
  parameter int NREQ            = 4,
  parameter int BRAM_ADDR_WIDTH = `ADDR_LEN,
  parameter int BRAM_DATA_WIDTH = `DATA_LEN
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NREQ-1:0]                 req_valid,
  input  logic [NREQ-1:0]                 req_we,
  input  logic [NREQ*BRAM_ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*BRAM_DATA_WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]                 req_ready,
  output logic [NREQ-1:0]                 rsp_valid,
  output logic [BRAM_DATA_WIDTH-1:0]      rsp_data,
  output logic [BRAM_ADDR_WIDTH-1:0]      ram_raddr,
  input  logic [BRAM_DATA_WIDTH-1:0]      ram_rdata,
  output logic [BRAM_ADDR_WIDTH-1:0]      ram_waddr,
  output logic [BRAM_DATA_WIDTH-1:0]      ram_wdata,
  output logic                            ram_we
);

  localparam int AW = BRAM_ADDR_WIDTH;
  localparam int DW = BRAM_DATA_WIDTH;
  localparam int PW = $clog2(NREQ);

  logic [NREQ-1:0] rd_req, wr_req;
  logic [NREQ-1:0] rd_gnt, wr_gnt;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [PW-1:0]   rd_idx, wr_idx;
  logic [PW-1:0]   rd_ptr_nxt, wr_ptr_nxt;
  logic            rd_any, wr_any;
  logic            byp_hit;
  logic            byp_q;
  logic [DW-1:0]   byp_data_q;

  assign rd_req = req_valid & ~req_we;
  assign wr_req = req_valid &  req_we;

  ram_rr_pick #(.N(NREQ), .PW(PW)) u_rd_pick (
    .req     (rd_req),
    .ptr     (rd_ptr),
    .gnt     (rd_gnt),
    .idx     (rd_idx),
    .any     (rd_any),
    .ptr_nxt (rd_ptr_nxt)
  );

  ram_rr_pick #(.N(NREQ), .PW(PW)) u_wr_pick (
    .req     (wr_req),
    .ptr     (wr_ptr),
    .gnt     (wr_gnt),
    .idx     (wr_idx),
    .any     (wr_any),
    .ptr_nxt (wr_ptr_nxt)
  );

  assign req_ready = rd_gnt | wr_gnt;
  assign ram_we    = wr_any;

  // Idle ports are driven to zero rather than left on the last requester's bus.
  always_comb begin
    ram_raddr = '0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (rd_any) begin
      ram_raddr = req_addr[int'(rd_idx)*AW +: AW];
    end
    if (wr_any) begin
      ram_waddr = req_addr[int'(wr_idx)*AW +: AW];
      ram_wdata = req_wdata[int'(wr_idx)*DW +: DW];
    end
  end

  // The RAM returns stale data on a same-cycle collision, so capture the write for forwarding.
  assign byp_hit = rd_any & wr_any & (ram_raddr == ram_waddr);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      rsp_valid  <= '0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      if (rd_any) rd_ptr <= rd_ptr_nxt;
      if (wr_any) wr_ptr <= wr_ptr_nxt;
      rsp_valid <= rd_gnt;
      byp_q     <= byp_hit;
      if (byp_hit) byp_data_q <= ram_wdata;
    end
  end

  assign rsp_data = byp_q ? byp_data_q : ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: a bench-owned RAM, a behavioural model
// checked every cycle, directed scenarios with literal expectations, then random traffic.

module tb_ram_port_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DW   = 16;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NREQ-1:0]      req_valid, req_we, req_ready, rsp_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [DW-1:0]        rsp_data, ram_rdata, ram_wdata;
  logic [AW-1:0]        ram_raddr, ram_waddr;
  logic                 ram_we;

  logic [AW-1:0]        t_addr  [NREQ];
  logic [DW-1:0]        t_wdata [NREQ];
  logic                 preload_en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .NREQ            (NREQ),
    .BRAM_ADDR_WIDTH (AW),
    .BRAM_DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW]  = t_addr[i];
      req_wdata[i*DW +: DW] = t_wdata[i];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 'h08) return 16'h1111;
    if (a >= 'h10 && a <= 'h13) return DW'('hA0 + a - 'h10);
    if (a == 'h30) return 16'h0077;
    return DW'(a * 59 + 7);
  endfunction

  // Bench-owned synchronous RAM: read returns the pre-write contents on a collision.
  logic [DW-1:0] ram_mem [0:255];
  always @(posedge clk) begin
    if (preload_en) begin
      for (int a = 0; a < 256; a++) ram_mem[a] <= init_val(a);
    end else if (ram_we) begin
      ram_mem[ram_waddr] <= ram_wdata;
    end
    ram_rdata <= ram_mem[ram_raddr];
  end

  // Round-robin rule: the requester closest above the pointer (cyclic distance) wins.
  function automatic int rr_pick(input logic [NREQ-1:0] req, input int ptr);
    int best, bestd, d;
    best  = -1;
    bestd = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      d = (i - ptr + NREQ) % NREQ;
      if (req[i] && d < bestd) begin
        best  = i;
        bestd = d;
      end
    end
    return best;
  endfunction

  // Reference model state.
  int              rd_ptr_m = 0;
  int              wr_ptr_m = 0;
  logic [NREQ-1:0] exp_v      = '0;
  logic [DW-1:0]   exp_d      = '0;
  logic [NREQ-1:0] last_gnt_m = '0;
  logic [DW-1:0]   mem_m [0:255];

  always @(negedge clk) begin
    logic [NREQ-1:0] rd_r, wr_r, exp_ready;
    logic [AW-1:0]   ra, wa;
    logic [DW-1:0]   wd;
    int              gr, gw;
    if (preload_en) begin
      for (int a = 0; a < 256; a++) mem_m[a] = init_val(a);
    end
    if (!reset_n) begin
      rd_ptr_m = 0;
      wr_ptr_m = 0;
      exp_v    = '0;
    end
    rd_r = req_valid & ~req_we;
    wr_r = req_valid &  req_we;
    gr = rr_pick(rd_r, rd_ptr_m);
    gw = rr_pick(wr_r, wr_ptr_m);
    exp_ready = '0;
    ra = '0;
    wa = '0;
    wd = '0;
    if (gr >= 0) begin
      exp_ready = exp_ready | (NREQ'(1) << gr);
      ra = t_addr[gr];
    end
    if (gw >= 0) begin
      exp_ready = exp_ready | (NREQ'(1) << gw);
      wa = t_addr[gw];
      wd = t_wdata[gw];
    end

    check("m_rsp_valid", 64'(rsp_valid), 64'(exp_v));
    if (exp_v != '0) check("m_rsp_data", 64'(rsp_data), 64'(exp_d));
    check("m_req_ready", 64'(req_ready), 64'(exp_ready));
    check("m_ram_we",    64'(ram_we),    64'(gw >= 0));
    check("m_ram_raddr", 64'(ram_raddr), 64'(ra));
    check("m_ram_waddr", 64'(ram_waddr), 64'(wa));
    check("m_ram_wdata", 64'(ram_wdata), 64'(wd));

    if (reset_n) begin
      exp_v = '0;
      if (gr >= 0) begin
        exp_v    = NREQ'(1) << gr;
        exp_d    = (gw >= 0 && wa == ra) ? wd : mem_m[ra];
        rd_ptr_m = (gr + 1) % NREQ;
      end
      if (gw >= 0) wr_ptr_m = (gw + 1) % NREQ;
      last_gnt_m = exp_ready;
    end else begin
      last_gnt_m = '0;
    end
    if (!preload_en && gw >= 0) mem_m[wa] = wd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [NREQ-1:0] v, input logic [NREQ-1:0] we);
    req_valid = v;
    req_we    = we;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n    = 1'b0;
    preload_en = 1'b1;
    req_valid  = '0;
    req_we     = '0;
    for (int i = 0; i < NREQ; i++) begin
      t_addr[i]  = '0;
      t_wdata[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    preload_en = 1'b0;
    check("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    check("reset_ram_we",    64'(ram_we),    64'h0);

    // Traffic, then reset right after a read was granted.
    reset_n = 1'b1;
    for (int i = 0; i < NREQ; i++) t_addr[i] = AW'('h10 + i);
    set_all(4'b1111, 4'b0000);
    tick();
    reset_n = 1'b0;
    #1;
    check("reset_drops_rsp", 64'(rsp_valid), 64'h0);
    tick();
    check("reset_rsp_stays0", 64'(rsp_valid), 64'h0);
    reset_n = 1'b1;

    // Read round-robin from pointer 0: grants 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rd_rr_gnt", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      if (k > 0) begin
        check("rd_rr_rsp_valid", 64'(rsp_valid), 64'(4'b0001 << ((k - 1) % 4)));
        check("rd_rr_rsp_data",  64'(rsp_data),  64'('hA0 + (k - 1) % 4));
      end
      tick();
    end

    // Write fairness: 0 and 2 contend for six cycles.
    set_all(4'b0101, 4'b0101);
    t_addr[0] = 8'h40;
    t_addr[2] = 8'h42;
    for (int c = 0; c < 6; c++) begin
      t_wdata[0] = DW'('h1000 + c);
      t_wdata[2] = DW'('h2000 + c);
      #1;
      if (c == 0) begin
        check("rd_rr_last_valid", 64'(rsp_valid), 64'h1);
        check("rd_rr_last_data",  64'(rsp_data),  64'hA0);
      end
      check("wr_fair_gnt", 64'(req_ready), (c % 2 == 1) ? 64'h4 : 64'h1);
      check("wr_fair_we",  64'(ram_we),    64'h1);
      tick();
    end

    // Concurrent read (req 2) and write (req 1).
    set_all(4'b0110, 4'b0010);
    t_addr[1]  = 8'h20;
    t_wdata[1] = 16'h0055;
    t_addr[2]  = 8'h30;
    #1;
    check("fair_mem_40", 64'(ram_mem[8'h40]), 64'h1004);
    check("fair_mem_42", 64'(ram_mem[8'h42]), 64'h2005);
    check("conc_ready",  64'(req_ready),      64'h6);
    check("conc_we",     64'(ram_we),         64'h1);
    check("conc_raddr",  64'(ram_raddr),      64'h30);
    check("conc_waddr",  64'(ram_waddr),      64'h20);
    tick();

    // Same-cycle bypass: req 0 writes 0x08 while req 3 reads 0x08.
    set_all(4'b1001, 4'b0001);
    t_addr[0]  = 8'h08;
    t_wdata[0] = 16'hDEAD;
    t_addr[3]  = 8'h08;
    #1;
    check("conc_rsp_valid", 64'(rsp_valid), 64'h4);
    check("conc_rsp_data",  64'(rsp_data),  64'h77);
    check("byp_ready",      64'(req_ready), 64'h9);
    tick();

    set_all(4'b1000, 4'b0000);
    #1;
    check("byp_rsp_valid", 64'(rsp_valid), 64'h8);
    check("byp_rsp_data",  64'(rsp_data),  64'hDEAD);
    check("conc_mem_20",   64'(ram_mem[8'h20]), 64'h55);
    tick();

    // Idle.
    set_all(4'b0000, 4'b0000);
    #1;
    check("reread_rsp_valid", 64'(rsp_valid), 64'h8);
    check("reread_rsp_data",  64'(rsp_data),  64'hDEAD);
    check("reread_byp_q",     64'(dut.byp_q), 64'h0);
    check("idle_ready",       64'(req_ready), 64'h0);
    check("idle_we",          64'(ram_we),    64'h0);
    check("idle_raddr",       64'(ram_raddr), 64'h0);
    tick();
    check("idle_rsp_valid", 64'(rsp_valid), 64'h0);

    // Random traffic; requesters hold a request until it is granted.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || last_gnt_m[i]) begin
          req_valid[i] = ($urandom_range(0, 99) < 65);
          req_we[i]    = 1'($urandom_range(0, 1));
          t_addr[i]    = AW'($urandom_range(0, 7));
          t_wdata[i]   = DW'($urandom);
        end
      end
      tick();
    end

    set_all(4'b0000, 4'b0000);
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
